// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//   Bundles the FIFO read port and the downstream valid/ready stream
//   seen by fifo_stream_reader.
//   master : the reader side (drives rd_en, m_valid, m_data)
//   slave  : the FIFO + consumer side (drives empty, data_out, underflow, m_ready)
//   Signals:
//     rd_en     FIFO read strobe
//     empty     FIFO empty flag
//     data_out  FIFO read data, valid the cycle after rd_en
//     underflow FIFO underflow flag, valid the cycle after rd_en
//     m_valid   stream word available
//     m_ready   consumer accepts the word
//     m_data    stream word
interface fifo_stream_reader_if #(
    parameter int unsigned FIFO_WIDTH = 16
);
    logic                  rd_en;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  underflow;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;

    modport master (
        output rd_en,
        input  empty,
        input  data_out,
        input  underflow,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  rd_en,
        output empty,
        output data_out,
        output underflow,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a synchronous FIFO's read port onto a valid/ready stream.
//   A read is issued only when the FIFO is non-empty and a slot in the
//   2-entry skid buffer is guaranteed for the word once it returns, which
//   absorbs the FIFO's one-cycle read latency at one word per cycle.
//   Ports:
//     clk           clock, all state on rising edge
//     rst_n         asynchronous active-low reset
//     rd_enable     allows new FIFO reads (an in-flight read still lands)
//     bus           FIFO read port + stream (master modport)
//     underflow_err sticky: a read returned with underflow set
//     word_count    words delivered on the stream, wraps
module fifo_stream_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_enable,
    fifo_stream_reader_if.master bus,
    output logic                 underflow_err,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int unsigned OCC_W    = 2;
    localparam int unsigned COMMIT_W = 3;

    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;

    logic                  pop_c;
    logic                  capture_c;
    logic [COMMIT_W-1:0]   committed_c;
    logic [OCC_W-1:0]      occ_next_c;

    // Stream side is a direct view of the buffer head
    assign bus.m_valid = (occ != OCC_W'(0));
    assign bus.m_data  = buf_mem[head];

    assign pop_c     = bus.m_valid && bus.m_ready;
    assign capture_c = inflight && !bus.underflow;

    // Slots that will be occupied after this cycle's pop; a new read is
    // safe while at most one is spoken for. Gated by rst_n so the strobe
    // drops immediately when reset is asserted.
    assign committed_c = COMMIT_W'(occ) + COMMIT_W'(inflight) - COMMIT_W'(pop_c);
    assign bus.rd_en   = rst_n && rd_enable && !bus.empty &&
                         (committed_c <= COMMIT_W'(1));

    // Occupancy update: a simultaneous capture and pop leaves occ unchanged
    always_comb begin
        occ_next_c = occ;
        if (capture_c && !pop_c) begin
            occ_next_c = occ + OCC_W'(1);
        end else if (!capture_c && pop_c) begin
            occ_next_c = occ - OCC_W'(1);
        end
    end

    // Buffer, pointers, read tracking and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ           <= '0;
            inflight      <= 1'b0;
            head          <= 1'b0;
            tail          <= 1'b0;
            buf_mem[0]    <= '0;
            buf_mem[1]    <= '0;
            underflow_err <= 1'b0;
            word_count    <= '0;
        end else begin
            inflight <= bus.rd_en;
            occ      <= occ_next_c;
            if (capture_c) begin
                buf_mem[tail] <= bus.data_out;
                tail          <= ~tail;
            end
            if (pop_c) begin
                head       <= ~head;
                word_count <= word_count + CNT_WIDTH'(1);
            end
            // A returned read flagged as underflow carries no data
            if (inflight && bus.underflow) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
